// File: rtl/nextuart_rx_fifo_pkg.sv
// Shared types and constants for the next-uart RX FIFO.
// Build option: NEXTUART_RXFIFO_OVF_EN enables drop-on-full with a sticky overflow flag.
package nextuart_rx_fifo_pkg;

    localparam logic [15:0] NEXT_UART_TX_PORT  = 16'h133B;
    localparam logic [15:0] NEXT_UART_RX_PORT  = 16'h143B;
    localparam logic [15:0] NEXT_UART_SEL_PORT = 16'h153B;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_ACK  = 1'b1
    } cap_state_e;

    function automatic logic [2:0] status_bits(
        input logic ovf,
        input logic full,
        input logic empty
    );
        return {ovf, full, empty};
    endfunction

endpackage

// File: rtl/nextuart_rx_fifo_if.sv
// Bundle between uart core, Z80 port decoder and the RX FIFO.
// Build option: NEXTUART_RXFIFO_OVF_EN (affects overflow only).
interface nextuart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    import nextuart_rx_fifo_pkg::*;

    logic [7:0]          uart_rxdata;
    logic                uart_rxrecv;
    logic                uart_data_read;
    logic                cpu_rd;
    logic                cpu_stat_rd;
    logic                cpu_flush;
    logic [7:0]          rdata;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                rts_n;

    modport master (
        output uart_rxdata, uart_rxrecv,
        output cpu_rd, cpu_stat_rd, cpu_flush,
        input  uart_data_read, rdata, empty,
        input  full, count, overflow, rts_n
    );

    modport slave (
        input  uart_rxdata, uart_rxrecv,
        input  cpu_rd, cpu_stat_rd, cpu_flush,
        output uart_data_read, rdata, empty,
        output full, count, overflow, rts_n
    );

endinterface

// File: rtl/nextuart_fifo_mem.sv
// Byte storage for the RX FIFO: sync write, async read.
// Build option: NEXTUART_RXFIFO_OVF_EN (not used here).
module nextuart_fifo_mem
    import nextuart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [7:0]            wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [7:0]            rdata_o
);

    logic [7:0] mem_q [2**DEPTH_LOG2];

    // write port; contents need no reset
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nextuart_rx_fifo.sv
// RX FIFO between uart core and Z80 port decoder with RTS flow control.
// Build option: NEXTUART_RXFIFO_OVF_EN drops bytes on full and sets overflow.
module nextuart_rx_fifo
    import nextuart_rx_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int RTS_MARGIN = 4
) (
    input logic               clk,
    input logic               rst_n,
    nextuart_rx_fifo_if.slave bus
);

    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] RTS_TH =
        CNT_W'(DEPTH - RTS_MARGIN);

    cap_state_e       state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rts_q;
    logic             cpu_rd_q;
    logic             stat_rd_q;

    logic       empty;
    logic       full;
    logic       pop;
    logic       accept;
    logic       drop;
    logic       push;
    logic       stat_clr;
    logic       data_read;
    logic [7:0] mem_rdata;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // pop once the Z80 IN cycle has ended; flush masks it
    assign pop = cpu_rd_q && !bus.cpu_rd &&
                 !empty && !bus.cpu_flush;

    assign accept = (state_q == CAP_IDLE) &&
                    bus.uart_rxrecv && (!full || pop);

    // a flushed push still acks the uart but stores nothing
    assign push = accept && !bus.cpu_flush;

    assign stat_clr = stat_rd_q && !bus.cpu_stat_rd;

    // capture FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= CAP_IDLE;
        else        state_q <= state_d;
    end

    // capture FSM next state
    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            (state_q == CAP_IDLE):
                if (accept || drop) state_d = CAP_ACK;
            (state_q == CAP_ACK):
                if (!bus.uart_rxrecv) state_d = CAP_IDLE;
            default: state_d = state_q;
        endcase
    end

    // capture FSM outputs, decoded from the state register
    always_comb begin
        data_read = (state_q == CAP_ACK);
    end

    // pointer and count next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.cpu_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)
                count_d = count_q + CNT_W'(1);
            else if (pop && !push)
                count_d = count_q - CNT_W'(1);
        end
    end

    // pointers, count, edge detectors and rts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rts_q     <= 1'b0;
            cpu_rd_q  <= 1'b0;
            stat_rd_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rts_q     <= (count_q >= RTS_TH);
            cpu_rd_q  <= bus.cpu_rd;
            stat_rd_q <= bus.cpu_stat_rd;
        end
    end

`ifdef NEXTUART_RXFIFO_OVF_EN
    logic ovf_q, ovf_d;

    assign drop = (state_q == CAP_IDLE) &&
                  bus.uart_rxrecv && full && !pop;

    // sticky overflow: set beats read-clear, flush beats all
    always_comb begin
        ovf_d = ovf_q;
        if (stat_clr)      ovf_d = 1'b0;
        if (drop)          ovf_d = 1'b1;
        if (bus.cpu_flush) ovf_d = 1'b0;
    end

    // overflow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign bus.overflow = ovf_q;
`else
    logic unused_stat_clr;

    assign drop            = 1'b0;
    assign unused_stat_clr = stat_clr;
    assign bus.overflow    = 1'b0;
`endif

    nextuart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.uart_rxdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign bus.uart_data_read = data_read;
    assign bus.rdata = empty ? 8'hFF : mem_rdata;
    assign bus.empty = empty;
    assign bus.full  = full;
    assign bus.count = count_q;
    assign bus.rts_n = rts_q;

endmodule

// File: tb/tb_nextuart_rx_fifo.sv
// Directed bench for nextuart_rx_fifo (depth 16, margin 4).
// Follows NEXTUART_RXFIFO_OVF_EN to pick the full-FIFO expectations.
module tb_nextuart_rx_fifo;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [7:0] q [$];

    nextuart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    nextuart_rx_fifo #(
        .DEPTH_LOG2 (4),
        .RTS_MARGIN (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // uart handshake; a missing ack is reported as a failure
    task automatic push_byte(input logic [7:0] b);
        bit seen;
        seen = 0;
        @(negedge clk);
        bus.uart_rxdata = b;
        bus.uart_rxrecv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.uart_data_read) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL push_ack byte=%h got no ack want ack", b);
        end
        bus.uart_rxrecv = 1'b0;
        @(negedge clk);
    endtask

    // one Z80 IN cycle; returns byte seen during the cycle
    task automatic pop_byte(output logic [7:0] seen);
        @(negedge clk);
        bus.cpu_rd = 1'b1;
        @(negedge clk);
        seen = bus.rdata;
        bus.cpu_rd = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 ||
            bus.full !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got c=%0d e=%b f=%b want 0 1 0",
                     bus.count, bus.empty, bus.full);
        end
        checks++;
        if (bus.overflow !== 1'b0 || bus.rts_n !== 1'b0 ||
            bus.uart_data_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got ovf=%b rts=%b ack=%b want 0 0 0",
                     bus.overflow, bus.rts_n, bus.uart_data_read);
        end
        checks++;
        if (bus.rdata !== 8'hFF) begin
            errors++;
            $display("FAIL reset_rdata got %h want ff", bus.rdata);
        end
    endtask

    task automatic test_basic;
        logic [7:0] s;
        push_byte(8'h41);
        push_byte(8'h42);
        checks++;
        if (bus.count !== 5'd2) begin
            errors++;
            $display("FAIL basic_count got %0d want 2", bus.count);
        end
        pop_byte(s);
        checks++;
        if (s !== 8'h41) begin
            errors++;
            $display("FAIL basic_rd0 got %h want 41", s);
        end
        pop_byte(s);
        checks++;
        if (s !== 8'h42) begin
            errors++;
            $display("FAIL basic_rd1 got %h want 42", s);
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.rdata !== 8'hFF) begin
            errors++;
            $display("FAIL basic_empty got e=%b d=%h want 1 ff",
                     bus.empty, bus.rdata);
        end
    endtask

    task automatic test_rts;
        logic [7:0] s;
        for (int i = 0; i < 11; i++) begin
            push_byte(8'h10 + 8'(i));
            q.push_back(8'h10 + 8'(i));
        end
        checks++;
        if (bus.count !== 5'd11 || bus.rts_n !== 1'b0) begin
            errors++;
            $display("FAIL rts_11 got c=%0d rts=%b want 11 0",
                     bus.count, bus.rts_n);
        end
        push_byte(8'h1B);
        q.push_back(8'h1B);
        checks++;
        if (bus.count !== 5'd12 || bus.rts_n !== 1'b1) begin
            errors++;
            $display("FAIL rts_12 got c=%0d rts=%b want 12 1",
                     bus.count, bus.rts_n);
        end
        pop_byte(s);
        @(negedge clk);
        checks++;
        if (s !== q[0] || bus.count !== 5'd11 ||
            bus.rts_n !== 1'b0) begin
            errors++;
            $display("FAIL rts_pop got d=%h c=%0d rts=%b want %h 11 0",
                     s, bus.count, bus.rts_n, q[0]);
        end
        void'(q.pop_front());
    endtask

    task automatic test_full;
        logic [7:0] s;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h1C + 8'(i));
            q.push_back(8'h1C + 8'(i));
        end
        checks++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL full_fill got c=%0d f=%b want 16 1",
                     bus.count, bus.full);
        end
`ifdef NEXTUART_RXFIFO_OVF_EN
        push_byte(8'h55);
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16 ||
            bus.rdata !== q[0]) begin
            errors++;
            $display("FAIL ovf_drop got o=%b c=%0d d=%h want 1 16 %h",
                     bus.overflow, bus.count, bus.rdata, q[0]);
        end
        @(negedge clk);
        bus.cpu_stat_rd = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_hold got %b want 1", bus.overflow);
        end
        bus.cpu_stat_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", bus.overflow);
        end
`else
        @(negedge clk);
        bus.uart_rxdata = 8'h55;
        bus.uart_rxrecv = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.uart_data_read !== 1'b0 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL bp_wait got ack=%b c=%0d want 0 16",
                     bus.uart_data_read, bus.count);
        end
        bus.cpu_rd = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rdata !== q[0]) begin
            errors++;
            $display("FAIL bp_head got %h want %h", bus.rdata, q[0]);
        end
        bus.cpu_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.uart_data_read !== 1'b1 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL bp_push got ack=%b c=%0d want 1 16",
                     bus.uart_data_read, bus.count);
        end
        bus.uart_rxrecv = 1'b0;
        @(negedge clk);
        void'(q.pop_front());
        q.push_back(8'h55);
`endif
        while (q.size() > 0) begin
            pop_byte(s);
            checks++;
            if (s !== q[0]) begin
                errors++;
                $display("FAIL drain got %h want %h", s, q[0]);
            end
            void'(q.pop_front());
        end
        checks++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL drain_empty got e=%b c=%0d want 1 0",
                     bus.empty, bus.count);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] s;
        for (int i = 0; i < 5; i++) begin
            push_byte(8'h30 + 8'(i));
            q.push_back(8'h30 + 8'(i));
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.cpu_rd = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.rdata !== q[0]) begin
                errors++;
                $display("FAIL b2b_head k=%0d got %h want %h",
                         k, bus.rdata, q[0]);
            end
            bus.cpu_rd = 1'b0;
            bus.uart_rxdata = 8'h40 + 8'(k);
            bus.uart_rxrecv = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.count !== 5'd5 || bus.uart_data_read !== 1'b1) begin
                errors++;
                $display("FAIL b2b_count k=%0d got c=%0d ack=%b want 5 1",
                         k, bus.count, bus.uart_data_read);
            end
            bus.uart_rxrecv = 1'b0;
            void'(q.pop_front());
            q.push_back(8'h40 + 8'(k));
            @(negedge clk);
        end
        while (q.size() > 0) begin
            pop_byte(s);
            checks++;
            if (s !== q[0]) begin
                errors++;
                $display("FAIL b2b_drain got %h want %h", s, q[0]);
            end
            void'(q.pop_front());
        end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) push_byte(8'h60 + 8'(i));
        @(negedge clk);
        bus.uart_rxdata = 8'h77;
        bus.uart_rxrecv = 1'b1;
        bus.cpu_flush   = 1'b1;
        @(negedge clk);
        bus.cpu_flush = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 ||
            bus.overflow !== 1'b0 || bus.rdata !== 8'hFF) begin
            errors++;
            $display("FAIL flush_clr got c=%0d e=%b o=%b d=%h want 0 1 0 ff",
                     bus.count, bus.empty, bus.overflow, bus.rdata);
        end
        checks++;
        if (bus.uart_data_read !== 1'b1) begin
            errors++;
            $display("FAIL flush_ack got %b want 1", bus.uart_data_read);
        end
        bus.uart_rxrecv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.uart_data_read !== 1'b0 || bus.count !== 5'd0) begin
            errors++;
            $display("FAIL flush_once got ack=%b c=%0d want 0 0",
                     bus.uart_data_read, bus.count);
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] s;
        push_byte(8'h98);
        @(negedge clk);
        bus.uart_rxdata = 8'h99;
        bus.uart_rxrecv = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.uart_data_read !== 1'b1 || bus.count !== 5'd2) begin
            errors++;
            $display("FAIL rmid_pre got ack=%b c=%0d want 1 2",
                     bus.uart_data_read, bus.count);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.uart_data_read !== 1'b0 || bus.count !== 5'd0 ||
            bus.rts_n !== 1'b0 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL rmid_rst got ack=%b c=%0d r=%b e=%b want 0 0 0 1",
                     bus.uart_data_read, bus.count, bus.rts_n, bus.empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.count !== 5'd1 || bus.uart_data_read !== 1'b1 ||
            bus.rdata !== 8'h99) begin
            errors++;
            $display("FAIL rmid_cap got c=%0d ack=%b d=%h want 1 1 99",
                     bus.count, bus.uart_data_read, bus.rdata);
        end
        bus.uart_rxrecv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.count !== 5'd1 || bus.uart_data_read !== 1'b0) begin
            errors++;
            $display("FAIL rmid_once got c=%0d ack=%b want 1 0",
                     bus.count, bus.uart_data_read);
        end
        pop_byte(s);
        checks++;
        if (s !== 8'h99 || bus.empty !== 1'b1) begin
            errors++;
            $display("FAIL rmid_pop got d=%h e=%b want 99 1",
                     s, bus.empty);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.uart_rxdata = 8'h00;
        bus.uart_rxrecv = 1'b0;
        bus.cpu_rd      = 1'b0;
        bus.cpu_stat_rd = 1'b0;
        bus.cpu_flush   = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_basic;
        test_rts;
        test_full;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
